// File: rtl/clk_divider.sv
// clk_divider: registered integer clock divider; outClk period is DIVIDE inClk cycles.
module clk_divider #(
    parameter int DIVIDE = 2,
    parameter int CNT_W  = $clog2(DIVIDE)
) (
    input  logic inClk,
    input  logic reset,
    output logic outClk
);
    if (DIVIDE < 2) begin : g_bad_divide
        $error("clk_divider: DIVIDE must be >= 2, got %0d", DIVIDE);
    end
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDE - 1);
    localparam logic [CNT_W-1:0] LOW  = CNT_W'(DIVIDE / 2);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    always_comb cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
    // Output high once the next count reaches LOW, so odd ratios get the extra high cycle.
    always_ff @(posedge inClk) begin
        if (reset) begin
            cnt    <= '0;
            outClk <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            outClk <= (cnt_next >= LOW);
        end
    end
endmodule

// File: tb/tb_clk_divider.sv
// tb_clk_divider: directed checks of DIVIDE = 2, 4 and 5 dividers against hand-computed waveforms.
module tb_clk_divider;
    logic in_clk = 1'b0;
    logic reset  = 1'b1;
    logic out2, out4, out5;
    int errors = 0;
    int checks = 0;
    logic [0:9] exp2 = 10'b1010101010;
    logic [0:9] exp4 = 10'b0110011001;
    logic [0:9] exp5 = 10'b0111001110;
    logic [2:0] cnt5 [0:9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    clk_divider #(.DIVIDE(2)) u2 (.inClk(in_clk), .reset(reset), .outClk(out2));
    clk_divider #(.DIVIDE(4)) u4 (.inClk(in_clk), .reset(reset), .outClk(out4));
    clk_divider #(.DIVIDE(5)) u5 (.inClk(in_clk), .reset(reset), .outClk(out5));

    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        repeat (2) @(negedge in_clk);
        check("rst_out2", 8'(out2), 8'd0);
        check("rst_out4", 8'(out4), 8'd0);
        check("rst_out5", 8'(out5), 8'd0);
        check("rst_cnt5", 8'(u5.cnt), 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge in_clk);
            check($sformatf("run_d2_e%0d", i + 1), 8'(out2), 8'(exp2[i]));
            check($sformatf("run_d4_e%0d", i + 1), 8'(out4), 8'(exp4[i]));
            check($sformatf("run_d5_e%0d", i + 1), 8'(out5), 8'(exp5[i]));
            check($sformatf("run_c5_e%0d", i + 1), 8'(u5.cnt), 8'(cnt5[i]));
        end
        // Held reset: 100 ns with no toggling.
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge in_clk);
            check($sformatf("hold_d2_%0d", i), 8'(out2), 8'd0);
            check($sformatf("hold_d4_%0d", i), 8'(out4), 8'd0);
        end
        reset = 1'b0;
        repeat (2) @(negedge in_clk);
        check("mid_pre_out4", 8'(out4), 8'd1);
        check("mid_pre_cnt4", 8'(u4.cnt), 8'd2);
        reset = 1'b1;
        @(negedge in_clk);
        check("mid_rst_out4", 8'(out4), 8'd0);
        check("mid_rst_cnt4", 8'(u4.cnt), 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge in_clk);
            check($sformatf("restart_d4_e%0d", i + 1), 8'(out4), 8'(exp4[i]));
            check($sformatf("restart_d5_e%0d", i + 1), 8'(out5), 8'(exp5[i]));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
